// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an asynchronous PWM line in clock
// cycles and flags a line stuck high or low when no completing edge arrives in time.
module pwm_capture #(
    parameter int N       = 20,
    parameter int TIMEOUT = 1048575
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         pwm_in,
    input  logic         enable,
    output logic [N-1:0] high_count,
    output logic [N-1:0] period_count,
    output logic         valid,
    output logic         stuck_high,
    output logic         stuck_low
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    localparam logic [N-1:0] TMO = N'(TIMEOUT);
    localparam logic [N-1:0] ONE = N'(1);

    state_t       state_q, state_d;
    logic         sync1_q, sync1_d;
    logic         sync2_q, sync2_d;
    logic         prev_q, prev_d;
    logic [N-1:0] per_cnt_q, per_cnt_d;
    logic [N-1:0] hi_cnt_q, hi_cnt_d;
    logic         idle_done_q, idle_done_d;
    logic [N-1:0] high_count_q, high_count_d;
    logic [N-1:0] period_count_q, period_count_d;
    logic         valid_q, valid_d;
    logic         stuck_high_q, stuck_high_d;
    logic         stuck_low_q, stuck_low_d;

    logic         rise, fall, timed_out;
    logic [N-1:0] per_inc, hi_inc;
    logic         report_stuck, stuck_level;

    assign rise      = sync2_q & ~prev_q;
    assign fall      = ~sync2_q & prev_q;
    assign timed_out = (per_cnt_q == TMO);

    // Counters saturate at TIMEOUT instead of wrapping.
    assign per_inc = timed_out ? per_cnt_q : per_cnt_q + ONE;
    assign hi_inc  = (hi_cnt_q == TMO) ? hi_cnt_q : hi_cnt_q + ONE;

    always_comb begin
        // NOTE: every variable gets a default first so no path below can infer a latch.
        sync1_d        = pwm_in;
        sync2_d        = sync1_q;
        prev_d         = sync2_q;
        state_d        = state_q;
        per_cnt_d      = per_cnt_q;
        hi_cnt_d       = hi_cnt_q;
        idle_done_d    = idle_done_q;
        high_count_d   = high_count_q;
        period_count_d = period_count_q;
        stuck_high_d   = stuck_high_q;
        stuck_low_d    = stuck_low_q;
        valid_d        = 1'b0;
        report_stuck   = 1'b0;
        stuck_level    = 1'b0;

        if (!enable) begin
            state_d     = S_IDLE;
            per_cnt_d   = '0;
            hi_cnt_d    = '0;
            idle_done_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        state_d   = S_HIGH;
                        per_cnt_d = ONE;
                        hi_cnt_d  = ONE;
                    end else if (fall) begin
                        // Any edge re-arms the idle timeout report.
                        per_cnt_d   = '0;
                        idle_done_d = 1'b0;
                    end else if (timed_out && !idle_done_q) begin
                        report_stuck = 1'b1;
                        stuck_level  = sync2_q;
                    end else begin
                        per_cnt_d = per_inc;
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        state_d   = S_LOW;
                        per_cnt_d = per_inc;
                    end else if (timed_out) begin
                        report_stuck = 1'b1;
                        stuck_level  = 1'b1;
                    end else begin
                        per_cnt_d = per_inc;
                        hi_cnt_d  = hi_inc;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        high_count_d   = hi_cnt_q;
                        period_count_d = per_cnt_q;
                        stuck_high_d   = 1'b0;
                        stuck_low_d    = 1'b0;
                        valid_d        = 1'b1;
                        state_d        = S_HIGH;
                        per_cnt_d      = ONE;
                        hi_cnt_d       = ONE;
                    end else if (timed_out) begin
                        report_stuck = 1'b1;
                        stuck_level  = 1'b0;
                    end else begin
                        per_cnt_d = per_inc;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // A stuck report is issued once, then waits in IDLE for a fresh edge.
            if (report_stuck) begin
                high_count_d   = '0;
                period_count_d = '0;
                stuck_high_d   = stuck_level;
                stuck_low_d    = ~stuck_level;
                valid_d        = 1'b1;
                state_d        = S_IDLE;
                per_cnt_d      = '0;
                hi_cnt_d       = '0;
                idle_done_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            prev_q         <= 1'b0;
            per_cnt_q      <= '0;
            hi_cnt_q       <= '0;
            idle_done_q    <= 1'b0;
            high_count_q   <= '0;
            period_count_q <= '0;
            valid_q        <= 1'b0;
            stuck_high_q   <= 1'b0;
            stuck_low_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            prev_q         <= prev_d;
            per_cnt_q      <= per_cnt_d;
            hi_cnt_q       <= hi_cnt_d;
            idle_done_q    <= idle_done_d;
            high_count_q   <= high_count_d;
            period_count_q <= period_count_d;
            valid_q        <= valid_d;
            stuck_high_q   <= stuck_high_d;
            stuck_low_q    <= stuck_low_d;
        end
    end

    assign high_count   = high_count_q;
    assign period_count = period_count_q;
    assign valid        = valid_q;
    assign stuck_high   = stuck_high_q;
    assign stuck_low    = stuck_low_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture (N=8, TIMEOUT=200): timestamp-based model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_pwm_capture;

    localparam int N   = 8;
    localparam int TMO = 200;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pwm_in;
    logic         enable;
    logic [N-1:0] high_count;
    logic [N-1:0] period_count;
    logic         valid;
    logic         stuck_high;
    logic         stuck_low;

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 1'b0;
    int cyc = 0;
    int vcyc[$];
    int rise_edges[$];
    logic [N-1:0] last_hc, last_pc;
    logic         last_sh, last_sl;

    pwm_capture #(.N(N), .TIMEOUT(TMO)) dut (
        .clock        (clk),
        .reset        (rst_n),
        .pwm_in       (pwm_in),
        .enable       (enable),
        .high_count   (high_count),
        .period_count (period_count),
        .valid        (valid),
        .stuck_high   (stuck_high),
        .stuck_low    (stuck_low)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: timestamps of edges seen on the synchronized line (pin delayed two samples).
    int   t, base, rise_t, fall_t;
    bit   measuring, fell, idle_done;
    logic p1, p2, p3;
    logic [N-1:0] exp_hc, exp_pc;
    logic exp_valid, exp_sh, exp_sl;

    function automatic int cap(input int v);
        return (v > TMO) ? TMO : v;
    endfunction

    task automatic model_reset();
        t = 0; base = 0; rise_t = 0; fall_t = 0;
        measuring = 0; fell = 0; idle_done = 0;
        p1 = 0; p2 = 0; p3 = 0;
        exp_hc = '0; exp_pc = '0; exp_valid = 0; exp_sh = 0; exp_sl = 0;
    endtask

    task automatic model_report(input logic lvl);
        exp_hc = '0; exp_pc = '0; exp_sh = lvl; exp_sl = ~lvl; exp_valid = 1;
        measuring = 0; idle_done = 1; base = t + 1;
    endtask

    task automatic model_step();
        logic syn, r, f;
        syn = p2;
        r = p2 & ~p3;
        f = ~p2 & p3;
        exp_valid = 0;
        if (!enable) begin
            measuring = 0; idle_done = 0; base = t + 1;
        end else if (!measuring) begin
            if (r) begin
                measuring = 1; fell = 0; rise_t = t;
            end else if (f) begin
                base = t + 1; idle_done = 0;
            end else if (!idle_done && (t - base) >= TMO) begin
                model_report(syn);
            end
        end else if (!fell) begin
            if (f) begin
                fell = 1; fall_t = t;
            end else if ((t - rise_t) >= TMO) begin
                model_report(1'b1);
            end
        end else begin
            if (r) begin
                exp_hc = N'(cap(fall_t - rise_t));
                exp_pc = N'(cap(t - rise_t));
                exp_sh = 0; exp_sl = 0; exp_valid = 1;
                rise_t = t; fell = 0;
            end else if ((t - rise_t) >= TMO) begin
                model_report(1'b0);
            end
        end
        p3 = p2; p2 = p1; p1 = pwm_in;
        t++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && valid) begin
            vcyc.push_back(cyc);
            last_hc <= high_count;
            last_pc <= period_count;
            last_sh <= stuck_high;
            last_sl <= stuck_low;
        end
    end

    always @(negedge clk) begin
        if (checking && rst_n) begin
            check("valid", 32'(valid), 32'(exp_valid));
            check("high_count", 32'(high_count), 32'(exp_hc));
            check("period_count", 32'(period_count), 32'(exp_pc));
            check("stuck_high", 32'(stuck_high), 32'(exp_sh));
            check("stuck_low", 32'(stuck_low), 32'(exp_sl));
        end
    end

    task automatic drive(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            if (lvl && !pwm_in) rise_edges.push_back(cyc + 1);
            pwm_in = lvl;
            @(negedge clk);
        end
    endtask

    task automatic pattern(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_high_count"}, 32'(high_count), 0);
        check({tag, "_period_count"}, 32'(period_count), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_stuck_high"}, 32'(stuck_high), 0);
        check({tag, "_stuck_low"}, 32'(stuck_low), 0);
    endtask

    initial begin
        int vb, rb, last;
        pwm_in = 1'b0;
        enable = 1'b0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_outputs_zero("reset");
        @(negedge clk);
        rst_n    = 1'b1;
        enable   = 1'b1;
        checking = 1'b1;
        drive(1'b0, 4);

        // 3 high / 5 low: first valid 3 edges after the 2nd rise, then every 8 cycles.
        vb = vcyc.size(); rb = rise_edges.size();
        pattern(3, 5, 6);
        #1;
        last = vcyc.size() - 1;
        check("s1_valid_count", vcyc.size() - vb, 5);
        check("s1_latency", vcyc[vb], rise_edges[rb + 1] + 2);
        check("s1_gap", vcyc[last] - vcyc[last - 1], 8);
        check("s1_high", 32'(last_hc), 3);
        check("s1_period", 32'(last_pc), 8);

        // 25% duty, period 64.
        vb = vcyc.size();
        pattern(16, 48, 3);
        #1;
        check("s2_valid_count", vcyc.size() - vb, 3);
        check("s2_high", 32'(last_hc), 16);
        check("s2_period", 32'(last_pc), 64);
        check("s2_stuck", 32'({last_sh, last_sl}), 0);

        // Held low: one stuck_low report, then recovery.
        vb = vcyc.size();
        drive(1'b0, 250);
        #1;
        check("s3_stuck_count", vcyc.size() - vb, 1);
        check("s3_stuck_low", 32'(last_sl), 1);
        check("s3_stuck_high", 32'(last_sh), 0);
        check("s3_counts", 32'({last_hc, last_pc}), 0);
        vb = vcyc.size();
        pattern(3, 5, 3);
        #1;
        check("s3_resume_count", vcyc.size() - vb, 2);
        check("s3_resume_stuck_low", 32'(last_sl), 0);
        check("s3_resume_high", 32'(last_hc), 3);
        check("s3_resume_period", 32'(last_pc), 8);

        // Held high after a rise: closing valid, one stuck_high report, then silence.
        vb = vcyc.size();
        drive(1'b1, 250);
        #1;
        check("s4_valid_count", vcyc.size() - vb, 2);
        check("s4_stuck_high", 32'(last_sh), 1);
        check("s4_counts", 32'({last_hc, last_pc}), 0);
        vb = vcyc.size();
        drive(1'b1, 250);
        #1;
        check("s4_no_repeat", vcyc.size() - vb, 0);

        // Async reset during the high phase.
        drive(1'b0, 10);
        pattern(3, 5, 2);
        drive(1'b1, 3);
        #1;
        check("s5_pre_high", 32'(high_count), 3);
        rst_n = 1'b0;
        #1 check_outputs_zero("s5_async");
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        vb = vcyc.size(); rb = rise_edges.size();
        drive(1'b0, 4);
        pattern(3, 5, 3);
        #1;
        check("s5_valid_count", vcyc.size() - vb, 2);
        check("s5_latency", vcyc[vb], rise_edges[rb + 1] + 2);

        // enable dropped mid-period, then re-enabled on a 1/1 input.
        drive(1'b1, 3);
        drive(1'b0, 2);
        enable = 1'b0;
        vb = vcyc.size();
        drive(1'b0, 3);
        pattern(3, 5, 2);
        #1;
        check("s6_disabled_valids", vcyc.size() - vb, 0);
        check("s6_hold_high", 32'(high_count), 3);
        check("s6_hold_period", 32'(period_count), 8);
        enable = 1'b1;
        vb = vcyc.size();
        pattern(1, 1, 5);
        drive(1'b0, 4);
        #1;
        check("s6_valid_count", vcyc.size() - vb, 4);
        check("s6_high", 32'(last_hc), 1);
        check("s6_period", 32'(last_pc), 2);
        check("s6_stuck", 32'({last_sh, last_sl}), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
